// File: rtl/i4201_clkgen.sv
// rtl/i4201_clkgen.sv - MCS-4 two-phase clock, power-on clear and run/step generator
//
// Purpose: derives the non-overlapping clk1/clk2 pair and poc for the
// i4001/i4002/i4004 chips from sysclk, with run/stop and single-instruction
// step control. Optional synthetic SYNC is built only when the macro
// I4201_SYNC_GEN_EN is defined; otherwise sync is tied low.
//
// Ports:
//   sysclk   in   system clock, all logic on its rising edge
//   reset    in   synchronous active-high reset
//   run      in   1 = free-run, 0 = stop at next instruction boundary
//   step     in   rising edge while stopped runs one instruction (8 clocks)
//   clk1     out  MCS-4 phase-1 clock
//   clk2     out  MCS-4 phase-2 clock
//   poc      out  power-on clear
//   sync     out  synthetic SYNC (high during X3 while running)
//   running  out  1 while clocks are toggling
//   subcycle out  clock index within the instruction cycle (0=A1 .. 7=X3)

module i4201_clkgen #(
    parameter int CLK_PERIOD = 67,
    parameter int CLK1_WIDTH = 20,
    parameter int CLK_GAP    = 13,
    parameter int CLK2_WIDTH = 20,
    parameter int POC_CYCLES = 64
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    output logic       clk1,
    output logic       clk2,
    output logic       poc,
    output logic       sync,
    output logic       running,
    output logic [2:0] subcycle
);

    localparam int CW = $clog2(CLK_PERIOD);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PERIOD - 1);
    localparam logic [CW-1:0] C1_END    = CW'(CLK1_WIDTH);
    localparam logic [CW-1:0] C2_START  = CW'(CLK1_WIDTH + CLK_GAP);
    localparam logic [CW-1:0] C2_END    = CW'(CLK1_WIDTH + CLK_GAP + CLK2_WIDTH);
    localparam logic [15:0]   POC_LAST  = 16'(POC_CYCLES - 1);

    if (CLK1_WIDTH + CLK_GAP + CLK2_WIDTH >= CLK_PERIOD) begin : g_bad_timing
        $error("i4201_clkgen: CLK1_WIDTH+CLK_GAP+CLK2_WIDTH must be less than CLK_PERIOD");
    end

    if (POC_CYCLES < 1 || POC_CYCLES > 65535) begin : g_bad_poc
        $error("i4201_clkgen: POC_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_RUN,
        S_STOPPING,
        S_STOPPED,
        S_STEP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [15:0]     poc_cnt;
    logic            step_q;
    logic            wrap;
    logic            step_edge;

    // Counting is gated by the registered running flag, so the first edge
    // after reset or a restart only arms the counter; clk1 then rises one
    // edge later from cnt=0.
    assign wrap      = running && (cnt == CNT_LAST);
    assign step_edge = step && !step_q;

    always_comb begin
        state_n = state;
        case (state)
            S_RUN: begin
                if (!run && !poc) begin
                    state_n = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (run) begin
                    state_n = S_RUN;
                end else if (wrap && subcycle == 3'd7) begin
                    state_n = S_STOPPED;
                end
            end
            S_STOPPED: begin
                // run has priority over a coincident step edge
                if (run) begin
                    state_n = S_RUN;
                end else if (step_edge) begin
                    state_n = S_STEP;
                end
            end
            S_STEP: begin
                if (wrap) begin
                    if (run) begin
                        state_n = S_RUN;
                    end else if (subcycle == 3'd7) begin
                        state_n = S_STOPPED;
                    end
                end
            end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= S_RUN;
            cnt      <= '0;
            subcycle <= 3'd0;
            poc_cnt  <= 16'd0;
            poc      <= 1'b1;
            step_q   <= 1'b0;
            running  <= 1'b0;
            clk1     <= 1'b0;
            clk2     <= 1'b0;
        end else begin
            state   <= state_n;
            step_q  <= step;
            running <= (state_n != S_STOPPED);

            if (state_n == S_STOPPED) begin
                cnt      <= '0;
                subcycle <= 3'd0;
            end else if (running) begin
                if (wrap) begin
                    cnt      <= '0;
                    subcycle <= subcycle + 3'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            clk1 <= running && (cnt < C1_END);
            clk2 <= running && (cnt >= C2_START) && (cnt < C2_END);

            // poc drops on the edge that registers the final wrap
            if (poc && wrap) begin
                if (poc_cnt == POC_LAST) begin
                    poc <= 1'b0;
                end else begin
                    poc_cnt <= poc_cnt + 16'd1;
                end
            end
        end
    end

`ifdef I4201_SYNC_GEN_EN
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync <= 1'b0;
        end else begin
            sync <= running && (subcycle == 3'd7);
        end
    end
`else
    assign sync = 1'b0;
`endif

endmodule

// File: tb/tb_i4201_clkgen.sv
// tb/tb_i4201_clkgen.sv - directed self-checking bench for i4201_clkgen

module tb_i4201_clkgen;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic       clk1;
    logic       clk2;
    logic       poc;
    logic       sync;
    logic       running;
    logic [2:0] subcycle;

    int checks = 0;
    int errors = 0;

    int ec   = 0;
    int base = 0;

    int r1 = 0;
    int r2 = 0;
    int ov = 0;
    int sh = 0;
    logic p1 = 1'b0;
    logic p2 = 1'b0;

`ifdef I4201_SYNC_GEN_EN
    localparam int SYNC_PER_INSTR = 67;
`else
    localparam int SYNC_PER_INSTR = 0;
`endif

    i4201_clkgen dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .clk1     (clk1),
        .clk2     (clk2),
        .poc      (poc),
        .sync     (sync),
        .running  (running),
        .subcycle (subcycle)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) ec <= ec + 1;

    always @(negedge sysclk) begin
        if (clk1 === 1'b1 && p1 !== 1'b1) r1 <= r1 + 1;
        if (clk2 === 1'b1 && p2 !== 1'b1) r2 <= r2 + 1;
        if (clk1 === 1'b1 && clk2 === 1'b1) ov <= ov + 1;
        if (sync === 1'b1) sh <= sh + 1;
        p1 <= clk1;
        p2 <= clk2;
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n, g, w, k, es;
        int r1_s, r2_s, sh_s;

        reset = 1'b1;
        run   = 1'b1;
        step  = 1'b0;

        // E0: reset edge
        cyc(1);
        base = ec;
        chk("rst_clk1", {31'd0, clk1}, 32'd0);
        chk("rst_clk2", {31'd0, clk2}, 32'd0);
        chk("rst_poc", {31'd0, poc}, 32'd1);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_subcycle", {29'd0, subcycle}, 32'd0);
        chk("rst_sync", {31'd0, sync}, 32'd0);
        reset = 1'b0;
        run   = 1'b0;
        r1_s  = r1;

        cyc(1);
        chk("e1_clk1_low", {31'd0, clk1}, 32'd0);
        chk("e1_running", {31'd0, running}, 32'd1);
        cyc(1);
        chk("e2_clk1_high", {31'd0, clk1}, 32'd1);

        n = 1;
        while (clk1 === 1'b1 && n < 100) begin
            cyc(1);
            if (clk1 === 1'b1) n++;
        end
        chk("clk1_width", n, 32'd20);

        g = 0;
        while (clk2 !== 1'b1 && g < 100) begin
            cyc(1);
            g++;
        end
        chk("clk_gap", g, 32'd13);

        w = 1;
        while (clk2 === 1'b1 && w < 100) begin
            cyc(1);
            if (clk2 === 1'b1) w++;
        end
        chk("clk2_width", w, 32'd20);

        k = 0;
        while (clk1 !== 1'b1 && k < 200) begin
            cyc(1);
            k++;
        end
        chk("period", ec - base - 2, 32'd67);

        // run=0 while poc is high must not stop the clocks
        for (int i = 0; i < 6000 && poc === 1'b1; i++) begin
            cyc(1);
            if (ec - base == 3000) begin
                chk("poc_run_ignored", {31'd0, running}, 32'd1);
                run = 1'b1;
            end
        end
        chk("poc_cleared", {31'd0, poc}, 32'd0);
        chk("poc_clear_edge", ec - base, 32'd4289);
        chk("poc_clk1_pulses", r1 - r1_s, 32'd64);
        chk("poc_subcycle", {29'd0, subcycle}, 32'd0);

        for (int i = 0; i < 200 && subcycle !== 3'd2; i++) cyc(1);
        chk("sub2_edge", ec - base, 32'd4423);
        run  = 1'b0;
        r1_s = r1;
        r2_s = r2;
        sh_s = sh;

        for (int i = 0; i < 1000 && running === 1'b1; i++) cyc(1);
        chk("stop_edge", ec - base, 32'd4825);
        chk("stop_clk1", {31'd0, clk1}, 32'd0);
        chk("stop_clk2", {31'd0, clk2}, 32'd0);
        chk("stop_subcycle", {29'd0, subcycle}, 32'd0);

        cyc(20);
        chk("stopped_running", {31'd0, running}, 32'd0);
        chk("stopped_clk1", {31'd0, clk1}, 32'd0);
        chk("stopped_subcycle", {29'd0, subcycle}, 32'd0);
        chk("stopped_sync", {31'd0, sync}, 32'd0);
        chk("drain_clk1_pulses", r1 - r1_s, 32'd6);
        chk("drain_clk2_pulses", r2 - r2_s, 32'd6);
        chk("drain_sync_len", sh - sh_s, SYNC_PER_INSTR);

        // single-instruction step
        r1_s = r1;
        r2_s = r2;
        sh_s = sh;
        step = 1'b1;
        cyc(1);
        es = ec - base;
        chk("step_start_running", {31'd0, running}, 32'd1);
        cyc(2);
        step = 1'b0;
        cyc(100);
        step = 1'b1;
        cyc(3);
        step = 1'b0;
        for (int i = 0; i < 1000 && running === 1'b1; i++) cyc(1);
        chk("step_len", ec - base - es, 32'd536);
        cyc(10);
        chk("step_still_stopped", {31'd0, running}, 32'd0);
        chk("step_clk1_pulses", r1 - r1_s, 32'd8);
        chk("step_clk2_pulses", r2 - r2_s, 32'd8);
        chk("step_sync_len", sh - sh_s, SYNC_PER_INSTR);

        // restart with a coincident step edge; run wins
        run  = 1'b1;
        step = 1'b1;
        cyc(1);
        chk("restart_running", {31'd0, running}, 32'd1);
        chk("restart_clk1_arm", {31'd0, clk1}, 32'd0);
        cyc(1);
        chk("restart_clk1", {31'd0, clk1}, 32'd1);
        step = 1'b0;

        // reset pulse in the middle of clk2
        for (int i = 0; i < 200 && clk2 !== 1'b1; i++) cyc(1);
        cyc(5);
        chk("pre_reset_clk2", {31'd0, clk2}, 32'd1);
        reset = 1'b1;
        cyc(1);
        base = ec;
        reset = 1'b0;
        chk("mid_rst_clk2", {31'd0, clk2}, 32'd0);
        chk("mid_rst_poc", {31'd0, poc}, 32'd1);
        chk("mid_rst_subcycle", {29'd0, subcycle}, 32'd0);
        chk("mid_rst_running", {31'd0, running}, 32'd0);
        cyc(2);
        chk("mid_rst_clk1_e2", {31'd0, clk1}, 32'd1);
        for (int i = 0; i < 6000 && poc === 1'b1; i++) cyc(1);
        chk("poc_restart_edge", ec - base, 32'd4289);

        chk("no_overlap", ov, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
